compressor_sched: RTL
=====================

# compressor_sched

Round-robin scheduler that shares one 11x11 partial-product compressor (21 columns, heights 1..11..1, 22-bit sum) among NREQ requesters. It accepts operand pairs, expands them into the packed partial-product bit matrix that drives the compressor, and tracks each operation through the compressor's fixed pipeline latency. It returns tagged 22-bit products through a credit-protected result FIFO, so a stalled consumer never drops a result. It sits between the multiplier clients and the compressor instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- LAT, 2: compressor pipeline depth in cycles, from pp to sum (0 = combinational).
- DEPTH, 4: result FIFO depth; must be >= 1. Full throughput requires DEPTH >= LAT+2.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*11  operand A, requester i at bits [11i+10:11i].
- req_b  in  NREQ*11  operand B, same packing.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid and ready are both high.
- pp  out  121  registered partial-product matrix to the compressor.
- pp_valid  out  1  pp holds a live operation.
- sum  in  22  compressor result (dst0..dst21, bit k = dst k).
- rsp_valid  out  1  FIFO head valid.
- rsp_id  out  3  requester index of the head entry.
- rsp_data  out  22  product of the head entry.
- rsp_ready  in  1  consumer accepts the head entry.
- idle  out  1  no operation in flight and FIFO empty.

## Operation
- Matrix: bit a[i]&b[j] goes to column k=i+j.
  - Column k height h(k)=min(k,20-k)+1.
  - Columns are packed ascending from pp bit 0. Within a column, bits are ordered by increasing i.
- Arbitration: round-robin pointer p, 0 after reset.
  - The grant goes to the first valid requester at or after p (mod NREQ), and only when credit>0.
  - After a grant to g, p becomes (g+1) mod NREQ. p is unchanged when there is no grant.
  - At most one grant per cycle.
  - req_ready is combinational from req_valid, p and registered credit. It is 0 during rst.
- Credit: credit = DEPTH - fifo_count - inflight, computed from registered counters.
  - Issue increments inflight.
  - A FIFO push decrements inflight and increments fifo_count.
  - A pop decrements fifo_count.
  - All counter updates are simultaneous and net at the same edge.
- Tag pipeline: a shift register of LAT+1 stages carries {valid, id} alongside the compressor.
  - When the last stage is valid, {id, sum} is pushed into the FIFO.
  - The FIFO never overflows. Overflow is an assertion failure in the bench.
- FIFO: pop when rsp_valid&rsp_ready. Push and pop in the same cycle are allowed at any occupancy, including full.
- Reset:
  - Clears pointer, tag pipeline, counters and FIFO. In-flight operations are discarded.
  - pp=0, pp_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, idle=1.
  - All outputs hold these values from the first edge with rst=1 until one edge after rst falls.

## Timing
- Handshake in cycle t:
  - pp and pp_valid update at edge t+1.
  - sum is sampled LAT cycles later, in cycle t+1+LAT.
  - The FIFO push occurs at the end of cycle t+1+LAT.
  - rsp_valid is high in cycle t+2+LAT at the earliest (latency LAT+2 when the FIFO is empty).
- pp_valid is 0 in any cycle following a cycle without a grant. pp holds its last value in that case; the compressor output for it is ignored.
- A credit freed by a pop at edge e becomes usable for a grant in the cycle after e.
- Steady state with rsp_ready=1 and DEPTH >= LAT+2: one product per cycle.
- With DEPTH < LAT+2, issue throttles to the credit limit.
- rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- idle is registered; it reflects counters after the last edge.

## Test plan
- Single op: requester 2 sends a=2047, b=2047 with LAT=2.
  - Required: pp_valid one cycle later.
  - Required: rsp_valid 4 cycles after the handshake, rsp_id=2, rsp_data=22'h3FF001.
- Fairness: all 4 requesters hold valid for 8 cycles with rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: 8 responses, in order, one per cycle.
- Backpressure: rsp_ready=0 and all valid, DEPTH=4.
  - Required: exactly 4 grants, then req_ready=0.
  - Required: raising rsp_ready for one cycle yields exactly one new grant on the following cycle.
- Matrix check: a=11'h001, b=11'h400.
  - Required: only pp bit index sum(h(0..9)) = 55 set in column 10 (i=0).
  - Required: rsp_data=22'h000400.
- Zero/edge operands: a=0 with b=2047 gives 0; a=1 with b=1 gives 1; a=1024 with b=1024 gives 22'h100000.
- Reset mid-flight: assert rst with 3 ops in flight and 2 queued.
  - Required: rsp_valid=0 and idle=1 the following cycle, and no stale responses after release.
  - Required: first grant after release goes to requester 0 when all are valid.

Source files
------------

// File: rtl/compressor_sched.sv
// Round-robin front end for one shared 11x11 partial-product compressor.
// It builds the pp matrix, tags each operation through the compressor pipeline
// and returns tagged products through a credit-protected result FIFO.
module compressor_sched #(
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*11-1:0]   req_a,
   input  logic [NREQ*11-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [120:0]         pp,
   output logic                 pp_valid,
   input  logic [21:0]          sum,
   output logic                 rsp_valid,
   output logic [2:0]           rsp_id,
   output logic [21:0]          rsp_data,
   input  logic                 rsp_ready,
   output logic                 idle
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1) + 1;

   typedef struct packed {
      logic [2:0]  id;
      logic [21:0] data;
   } rsp_t;

   logic [2:0]           ptr_q, ptr_d;
   logic [2:0]           gnt_id;
   logic                 gnt_any;
   logic                 credit_ok;
   logic [10:0]          sel_a, sel_b;
   logic [120:0]         pp_d, pp_q;
   logic [LAT:0]         tvld_q;
   logic [LAT:0][2:0]    tid_q;
   logic [CW-1:0]        infl_q, infl_d, fcnt_q, fcnt_d;
   logic                 push, pop;
   rsp_t                 mem_q [DEPTH];
   logic [AW-1:0]        wr_q, rd_q;
   logic                 idle_q;

   function automatic int col_off(input int k);
      int s;
      s = 0;
      for (int m = 0; m < k; m++) s += (m <= 10) ? m + 1 : 21 - m;
      return s;
   endfunction

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Everything issued and not yet popped holds a FIFO slot in reserve.
   assign credit_ok = ({1'b0, fcnt_q} + {1'b0, infl_q}) < (CW + 1)'(DEPTH);

   always_comb begin
      logic [3:0] cand;
      logic [7:0] vpad;
      vpad    = 8'(req_valid);
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + 4'(k);
         if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
         if (!gnt_any && vpad[cand[2:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = cand[2:0];
         end
      end
      if (rst || !credit_ok) gnt_any = 1'b0;
   end

   always_comb begin
      sel_a     = '0;
      sel_b     = '0;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = gnt_any && (gnt_id == 3'(i));
         if (gnt_id == 3'(i)) begin
            sel_a = req_a[11*i +: 11];
            sel_b = req_b[11*i +: 11];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (gnt_id == 3'(NREQ - 1)) ? 3'd0 : gnt_id + 3'd1;
   end

   // Column k holds a[i]&b[k-i], lowest i first; columns packed from bit 0.
   for (genvar k = 0; k < 21; k++) begin : g_col
      localparam int ILO = (k > 10) ? k - 10 : 0;
      localparam int IHI = (k < 10) ? k : 10;
      for (genvar i = ILO; i <= IHI; i++) begin : g_bit
         assign pp_d[col_off(k) + i - ILO] = sel_a[i] & sel_b[k - i];
      end
   end

   assign push = tvld_q[LAT];
   assign pop  = rsp_valid && rsp_ready;

   always_comb begin
      infl_d = infl_q + CW'(gnt_any) - CW'(push);
      fcnt_d = fcnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         pp_q   <= '0;
         tvld_q <= '0;
         tid_q  <= '0;
         infl_q <= '0;
         fcnt_q <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         idle_q <= 1'b1;
      end else begin
         ptr_q     <= ptr_d;
         if (gnt_any) pp_q <= pp_d;
         tvld_q[0] <= gnt_any;
         tid_q[0]  <= gnt_id;
         for (int s = 1; s <= LAT; s++) begin
            tvld_q[s] <= tvld_q[s-1];
            tid_q[s]  <= tid_q[s-1];
         end
         infl_q <= infl_d;
         fcnt_q <= fcnt_d;
         if (push) wr_q <= nxt(wr_q);
         if (pop)  rd_q <= nxt(rd_q);
         idle_q <= (infl_d == '0) && (fcnt_d == '0);
      end
   end

   // Storage needs no reset; the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= '{id: tid_q[LAT], data: sum};
   end

   assign pp        = pp_q;
   assign pp_valid  = tvld_q[0];
   assign rsp_valid = (fcnt_q != '0);
   assign rsp_id    = rsp_valid ? mem_q[rd_q].id   : '0;
   assign rsp_data  = rsp_valid ? mem_q[rd_q].data : '0;
   assign idle      = idle_q;

endmodule
